csdf_1p_4f_split: RTL and testbench
===================================

Name: csdf_1p_4f_split

Overview:
- Cyclo-static dataflow actor that consumes 1 token per cycle-period and produces RATE tokens.
- It is the producer-side counterpart of the 4-to-1 accumulating actor.
- Each input word X is split into RATE output words whose unsigned sum equals X exactly. The remainder is distributed over the first phases.
- It sits between two FWFT FIFOs in the dataflow fabric, using the same empty/rd and full/wr handshake as the other actors.

Parameters:
- WIDTH, 32, data width of input and output tokens.
- LOG2_RATE, 2, log2 of the production rate. RATE = 2**LOG2_RATE output tokens per input token. Legal range 1..4.
- c0_IDLE, 0, encoding of the idle state.
- c0_EMIT, 1, encoding of the emit state.

Ports:
- ck  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in0_data  input  WIDTH  head of upstream FIFO; valid whenever in0_empty=0.
- in0_empty  input  1  upstream FIFO empty.
- in0_rd  output  1  pop upstream FIFO this cycle; in0_data is consumed in the same cycle.
- out0_full  input  1  downstream FIFO full.
- out0_wr  output  1  push out0_data into downstream FIFO this cycle.
- out0_data  output  WIDTH  output token.

Behaviour:
- Registers:
  - c0_state (1 bit).
  - c0_q (WIDTH bits): quotient X >> LOG2_RATE.
  - c0_r (LOG2_RATE bits): remainder X[LOG2_RATE-1:0].
  - c0_ph (LOG2_RATE bits): phase counter.
- Reset (async, any time, including mid-burst):
  - c0_state=IDLE; c0_q=0, c0_r=0, c0_ph=0.
  - in0_rd=0, out0_wr=0, out0_data=0 while rst is high.
  - A partially emitted burst is discarded. No further writes for that token.
- Outputs in0_rd, out0_wr and out0_data are combinational from state and inputs. No registered output stage.
- IDLE:
  - out0_wr=0; out0_data=0.
  - in0_rd = ~in0_empty.
  - On pop: c0_q <= in0_data>>LOG2_RATE; c0_r <= in0_data[LOG2_RATE-1:0]; c0_ph <= 0; next state EMIT. Otherwise stay in IDLE.
- EMIT:
  - out0_data = c0_q + (c0_ph < c0_r ? 1 : 0). Never overflows, because c0_q < 2**(WIDTH-LOG2_RATE).
  - out0_wr = ~out0_full.
  - If out0_full=1: all registers hold, in0_rd=0, and the same out0_data stays stable.
  - On write with c0_ph != RATE-1: c0_ph <= c0_ph+1; in0_rd=0.
  - On write with c0_ph == RATE-1 (last phase):
    - in0_rd = ~in0_empty.
    - If popping, load the new c0_q/c0_r, set c0_ph <= 0, and stay in EMIT (back-to-back, no bubble).
    - Otherwise c0_ph <= 0, c0_q <= 0, c0_r <= 0, next state IDLE.
- in0_rd is never asserted in EMIT except in the last-phase write cycle.
- out0_wr is never asserted in IDLE.
- Latency: pop in cycle N, first write at earliest in cycle N+1.
- Sustained throughput: RATE outputs per input, 1 output per cycle with no bubbles when upstream is non-empty and downstream is non-full.
- Simultaneous events:
  - Last-phase write together with in0_empty going 0 in the same cycle: the pop happens (in0_empty is sampled combinationally).
  - out0_full=1 during the last phase: no pop, hold.
- Conservation invariant: for every consumed X, the sum of its RATE emitted tokens equals X mod 2**WIDTH, and the tokens are emitted in phase order 0..RATE-1.

Test Plan:
- Single token X=10, RATE=4, no backpressure -> in0_rd pulses 1 cycle. out0_wr high for 4 consecutive cycles starting the next cycle. out0_data 3,3,2,2. Then IDLE, out0_wr=0.
- Tokens 3 and 0xFFFFFFFF back-to-back -> 1,1,1,0 then 0x40000000,0x40000000,0x40000000,0x3FFFFFFF. 8 consecutive writes. Second in0_rd coincides with the 4th write of the first token.
- X=7 with out0_full=1 for 3 cycles after the second write -> out0_data held at 2 with out0_wr=0 during the stall. Sequence 2,2,2,1 is preserved. No extra pop while full.
- Upstream empty after the first token: X=4 -> 1,1,1,1. in0_rd stays 0 until in0_empty falls. Next token popped from IDLE with a 1-cycle bubble.
- Assert rst after the 2nd output of X=100 -> outputs 0 immediately (async). After release, the next token 9 yields 3,2,2,2. No leftover writes from 100.
- LOG2_RATE=1 build, X=5 -> 3,2. Scoreboard check over 1000 random tokens with random empty/full: per-token sum equals X, and no write occurs while full.

Source files
------------

// File: rtl/csdf_1p_4f_split.sv
// Cyclo-static split actor: pops one word X and emits 2**LOG2_RATE words summing to X,
// with the remainder spread over the leading phases. FWFT empty/rd in, full/wr out.
module csdf_1p_4f_split #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LOG2_RATE = 2,
  parameter logic        c0_IDLE   = 1'b0,
  parameter logic        c0_EMIT   = 1'b1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_empty,
  output logic             in0_rd,
  input  logic             out0_full,
  output logic             out0_wr,
  output logic [WIDTH-1:0] out0_data
);

  typedef enum logic {
    IDLE = c0_IDLE,
    EMIT = c0_EMIT
  } state_t;

  localparam logic [LOG2_RATE-1:0] PhLast = '1;

  state_t               c0_state;
  logic [WIDTH-1:0]     c0_q;
  logic [LOG2_RATE-1:0] c0_r;
  logic [LOG2_RATE-1:0] c0_ph;

  logic w_last;
  logic w_inc;

  assign w_last = (c0_ph == PhLast);
  assign w_inc  = (c0_ph < c0_r);

  // Handshakes are combinational so a last-phase write can pop the next token in the same cycle.
  always_comb begin
    in0_rd    = 1'b0;
    out0_wr   = 1'b0;
    out0_data = '0;
    if (!rst) begin
      if (c0_state == IDLE) begin
        in0_rd = ~in0_empty;
      end else begin
        out0_data = c0_q + {{(WIDTH-1){1'b0}}, w_inc};
        out0_wr   = ~out0_full;
        in0_rd    = ~out0_full & w_last & ~in0_empty;
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      c0_state <= IDLE;
      c0_q     <= '0;
      c0_r     <= '0;
      c0_ph    <= '0;
    end else begin
      case (c0_state)
        IDLE: begin
          if (in0_rd) begin
            c0_q     <= in0_data >> LOG2_RATE;
            c0_r     <= in0_data[LOG2_RATE-1:0];
            c0_ph    <= '0;
            c0_state <= EMIT;
          end
        end
        EMIT: begin
          if (out0_wr) begin
            if (!w_last) begin
              c0_ph <= c0_ph + 1'b1;
            end else if (in0_rd) begin
              c0_q  <= in0_data >> LOG2_RATE;
              c0_r  <= in0_data[LOG2_RATE-1:0];
              c0_ph <= '0;
            end else begin
              c0_q     <= '0;
              c0_r     <= '0;
              c0_ph    <= '0;
              c0_state <= IDLE;
            end
          end
        end
        default: c0_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csdf_1p_4f_split.sv
// Bench for csdf_1p_4f_split: directed cycle checks on RATE=4 and RATE=2 builds, plus a
// scoreboarded random run with per-word and per-token-sum checks on the RATE=4 build.
module tb_csdf_1p_4f_split;

  logic        ck;
  logic        rst;
  logic [31:0] a_data, b_data;
  logic        a_empty, b_empty;
  logic        a_rd, b_rd;
  logic        a_full, b_full;
  logic        a_wr, b_wr;
  logic [31:0] a_out, b_out;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  logic [31:0] exp_q[$];
  logic [31:0] x_q[$];
  logic [31:0] acc;
  int          wcnt;

  csdf_1p_4f_split #(.WIDTH(32), .LOG2_RATE(2)) dut_a (
    .ck        (ck),
    .rst       (rst),
    .in0_data  (a_data),
    .in0_empty (a_empty),
    .in0_rd    (a_rd),
    .out0_full (a_full),
    .out0_wr   (a_wr),
    .out0_data (a_out)
  );

  csdf_1p_4f_split #(.WIDTH(32), .LOG2_RATE(1)) dut_b (
    .ck        (ck),
    .rst       (rst),
    .in0_data  (b_data),
    .in0_empty (b_empty),
    .in0_rd    (b_rd),
    .out0_full (b_full),
    .out0_wr   (b_wr),
    .out0_data (b_out)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge ck);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic rd, input logic wr, input logic [31:0] d);
    @(negedge ck);
    chk({tag, ".rd"}, {31'b0, a_rd}, {31'b0, rd});
    chk({tag, ".wr"}, {31'b0, a_wr}, {31'b0, wr});
    chk({tag, ".data"}, a_out, d);
    adv();
  endtask

  task automatic expect_b(input string tag, input logic rd, input logic wr, input logic [31:0] d);
    @(negedge ck);
    chk({tag, ".rd"}, {31'b0, b_rd}, {31'b0, rd});
    chk({tag, ".wr"}, {31'b0, b_wr}, {31'b0, wr});
    chk({tag, ".data"}, b_out, d);
    adv();
  endtask

  // Scoreboard for dut_a: every pop pushes four expected words; every write pops one.
  always @(negedge ck) begin
    if (rst) begin
      exp_q.delete();
      x_q.delete();
      acc  = '0;
      wcnt = 0;
    end else begin
      if (a_full) chk("sb.wr_while_full", {31'b0, a_wr}, 32'd0);
      if (a_wr) begin
        if (exp_q.size() == 0) begin
          chk("sb.unexpected_wr", {31'b0, a_wr}, 32'd0);
        end else begin
          chk("sb.word", a_out, exp_q.pop_front());
          acc  = acc + a_out;
          wcnt = wcnt + 1;
          if (wcnt == 4) begin
            chk("sb.token_sum", acc, x_q.pop_front());
            acc  = '0;
            wcnt = 0;
          end
        end
      end
      if (a_rd) begin
        n_pop++;
        x_q.push_back(a_data);
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back((a_data / 4) + ((i < int'(a_data % 4)) ? 32'd1 : 32'd0));
        end
      end
    end
  end

  initial begin
    bit popped;
    int cyc;
    rst = 1'b1;
    a_data = '0; a_empty = 1'b1; a_full = 1'b0;
    b_data = '0; b_empty = 1'b1; b_full = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    expect_a("reset_hold", 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    expect_a("idle", 1'b0, 1'b0, 32'd0);

    // X=10 -> 3,3,2,2
    a_data = 32'd10; a_empty = 1'b0;
    expect_a("t1.pop", 1'b1, 1'b0, 32'd0);
    a_empty = 1'b1;
    expect_a("t1.w0", 1'b0, 1'b1, 32'd3);
    expect_a("t1.w1", 1'b0, 1'b1, 32'd3);
    expect_a("t1.w2", 1'b0, 1'b1, 32'd2);
    expect_a("t1.w3", 1'b0, 1'b1, 32'd2);
    expect_a("t1.idle", 1'b0, 1'b0, 32'd0);

    // 3 then 0xFFFFFFFF back-to-back
    a_data = 32'd3; a_empty = 1'b0;
    expect_a("t2.pop0", 1'b1, 1'b0, 32'd0);
    a_data = 32'hFFFF_FFFF;
    expect_a("t2.w0", 1'b0, 1'b1, 32'd1);
    expect_a("t2.w1", 1'b0, 1'b1, 32'd1);
    expect_a("t2.w2", 1'b0, 1'b1, 32'd1);
    expect_a("t2.w3pop", 1'b1, 1'b1, 32'd0);
    a_empty = 1'b1;
    expect_a("t2.w4", 1'b0, 1'b1, 32'h4000_0000);
    expect_a("t2.w5", 1'b0, 1'b1, 32'h4000_0000);
    expect_a("t2.w6", 1'b0, 1'b1, 32'h4000_0000);
    expect_a("t2.w7", 1'b0, 1'b1, 32'h3FFF_FFFF);
    expect_a("t2.idle", 1'b0, 1'b0, 32'd0);

    // X=7 with a 3-cycle stall after the second write, then full during the last phase
    a_data = 32'd7; a_empty = 1'b0;
    expect_a("t3.pop", 1'b1, 1'b0, 32'd0);
    a_empty = 1'b1;
    expect_a("t3.w0", 1'b0, 1'b1, 32'd2);
    expect_a("t3.w1", 1'b0, 1'b1, 32'd2);
    a_full = 1'b1; a_data = 32'd12; a_empty = 1'b0;
    expect_a("t3.stall0", 1'b0, 1'b0, 32'd2);
    expect_a("t3.stall1", 1'b0, 1'b0, 32'd2);
    expect_a("t3.stall2", 1'b0, 1'b0, 32'd2);
    a_full = 1'b0;
    expect_a("t3.w2", 1'b0, 1'b1, 32'd2);
    a_full = 1'b1;
    expect_a("t3.last_full", 1'b0, 1'b0, 32'd1);
    a_full = 1'b0;
    expect_a("t3.w3pop", 1'b1, 1'b1, 32'd1);
    a_empty = 1'b1;
    for (int i = 0; i < 4; i++) expect_a("t3.x12", 1'b0, 1'b1, 32'd3);
    expect_a("t3.idle", 1'b0, 1'b0, 32'd0);

    // X=4 with upstream empty afterwards, then 8 from IDLE
    a_data = 32'd4; a_empty = 1'b0;
    expect_a("t4.pop", 1'b1, 1'b0, 32'd0);
    a_empty = 1'b1;
    for (int i = 0; i < 4; i++) expect_a("t4.w", 1'b0, 1'b1, 32'd1);
    expect_a("t4.idle0", 1'b0, 1'b0, 32'd0);
    expect_a("t4.idle1", 1'b0, 1'b0, 32'd0);
    a_data = 32'd8; a_empty = 1'b0;
    expect_a("t4.pop8", 1'b1, 1'b0, 32'd0);
    a_empty = 1'b1;
    for (int i = 0; i < 4; i++) expect_a("t4.x8", 1'b0, 1'b1, 32'd2);
    expect_a("t4.idle2", 1'b0, 1'b0, 32'd0);

    // Reset mid-burst of X=100, then 9 -> 3,2,2,2
    a_data = 32'd100; a_empty = 1'b0;
    expect_a("t5.pop", 1'b1, 1'b0, 32'd0);
    a_empty = 1'b1;
    expect_a("t5.w0", 1'b0, 1'b1, 32'd25);
    expect_a("t5.w1", 1'b0, 1'b1, 32'd25);
    rst = 1'b1;
    #1;
    chk("t5.rst.wr", {31'b0, a_wr}, 32'd0);
    chk("t5.rst.data", a_out, 32'd0);
    a_data = 32'd9; a_empty = 1'b0;
    #1;
    chk("t5.rst.rd", {31'b0, a_rd}, 32'd0);
    @(negedge ck);
    adv();
    rst = 1'b0;
    expect_a("t5.pop9", 1'b1, 1'b0, 32'd0);
    a_empty = 1'b1;
    expect_a("t5.w0b", 1'b0, 1'b1, 32'd3);
    for (int i = 0; i < 3; i++) expect_a("t5.w", 1'b0, 1'b1, 32'd2);
    expect_a("t5.idle", 1'b0, 1'b0, 32'd0);

    // RATE=2 build: 5 -> 3,2 then 0xFFFFFFFF back-to-back
    b_data = 32'd5; b_empty = 1'b0;
    expect_b("r2.pop", 1'b1, 1'b0, 32'd0);
    b_data = 32'hFFFF_FFFF;
    expect_b("r2.w0", 1'b0, 1'b1, 32'd3);
    expect_b("r2.w1pop", 1'b1, 1'b1, 32'd2);
    b_empty = 1'b1;
    expect_b("r2.w2", 1'b0, 1'b1, 32'h8000_0000);
    expect_b("r2.w3", 1'b0, 1'b1, 32'h7FFF_FFFF);
    expect_b("r2.idle", 1'b0, 1'b0, 32'd0);

    // Random traffic on dut_a, checked entirely by the scoreboard
    n_pop = 0;
    cyc = 0;
    while (n_pop < 1000 && cyc < 20000) begin
      @(negedge ck);
      popped = a_rd;
      adv();
      cyc++;
      if (popped || a_empty) begin
        a_empty = ($urandom_range(3) == 0);
        a_data  = $urandom();
      end
      a_full = ($urandom_range(3) == 0);
    end
    if (n_pop < 1000) chk("rand.timeout", n_pop, 32'd1000);
    a_empty = 1'b1;
    a_full  = 1'b0;
    repeat (8) adv();
    @(negedge ck);
    chk("rand.drain_words", exp_q.size(), 32'd0);
    chk("rand.drain_tokens", x_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
